// File: rtl/suma_serial.sv
// suma_serial: bit-serial adder, R = A + B computed LSB first through one
// full-adder cell and a carry flip-flop. start/busy/done handshake with
// carry (C), signed overflow (V) and zero (Z) flags.
module suma_serial #(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] R,
  output logic         C,
  output logic         V,
  output logic         Z
);

  localparam int CW = (M > 2) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [M-1:0]   a_reg;
  logic [M-1:0]   b_reg;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic           a_bit;
  logic           b_bit;
  logic           sum_bit;
  logic           carry_out;
  logic           last_bit;
  logic [M-1:0]   r_next;

  // State register; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept in IDLE, run M bit-steps, single DONE cycle.
  always_comb begin
    // NOTE: default first so every path assigns state_next; no latch inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Full-adder cell on the current bit position of the latched operands.
  always_comb begin
    a_bit     = a_reg[cnt];
    b_bit     = b_reg[cnt];
    sum_bit   = a_bit ^ b_bit ^ carry;
    carry_out = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    last_bit  = (cnt == LAST_BIT);
  end

  // Result as it will look after this step, used for the zero flag so the
  // freshly written MSB is included.
  always_comb begin
    r_next      = R;
    r_next[cnt] = sum_bit;
  end

  // Datapath: operand capture, bit-serial sum, carry chain and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      R     <= '0;
      C     <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          R[cnt] <= sum_bit;
          carry  <= carry_out;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            // carry holds the carry into the MSB at this step.
            C <= carry_out;
            V <= carry ^ carry_out;
            Z <= (r_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode directly from state so reset clears them at once.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_suma_serial.sv
// tb_suma_serial: directed self-checking bench for suma_serial (M = 4).
module tb_suma_serial;

  localparam int M = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic         busy;
  logic         done;
  logic [M-1:0] R;
  logic         C;
  logic         V;
  logic         Z;

  int n_tests = 0;
  int n_fail  = 0;

  suma_serial #(.M(M)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .R     (R),
    .C     (C),
    .V     (V),
    .Z     (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One addition: start for one cycle, optionally disturb A/B/start mid-RUN,
  // then check latency, busy length, result and flags.
  task automatic run_add(input string tag, input logic [M-1:0] a, input logic [M-1:0] b,
                         input logic [M-1:0] er, input logic ec, input logic ev,
                         input logic ez, input bit disturb);
    int n;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);            // accept edge has passed
    start = 1'b0;
    n = 1; busy_cnt = 0; seen = 0;
    if (busy) busy_cnt++;
    for (int i = 0; i < 20; i++) begin
      if (disturb && n == 2) begin A = '0; B = '0; start = 1'b1; end
      if (disturb && n == 3) start = 1'b0;
      @(negedge clk);
      n++;
      if (done) begin seen = 1; break; end
      if (busy) busy_cnt++;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(M + 1));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(M));
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    check({tag, " R"}, 32'(R), 32'(er));
    check({tag, " C"}, 32'(C), 32'(ec));
    check({tag, " V"}, 32'(V), 32'(ev));
    check({tag, " Z"}, 32'(Z), 32'(ez));
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " R_held"}, 32'(R), 32'(er));
  endtask

  initial begin
    int pulses;
    int busy_low;
    int last_done;
    int gap_bad;
    int r_bad;

    rst = 1'b0; start = 1'b0; A = '0; B = '0;

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst R",    32'(R), 32'd0);
    check("rst flags", {29'd0, C, V, Z}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle without start: done must never pulse.
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("idle no activity", 32'(pulses), 32'd0);

    run_add("3+5",  4'd3,  4'd5, 4'b1000, 1'b0, 1'b1, 1'b0, 0);
    run_add("15+1", 4'd15, 4'd1, 4'd0,    1'b1, 1'b0, 1'b1, 0);
    run_add("8+8",  4'd8,  4'd8, 4'd0,    1'b1, 1'b1, 1'b1, 0);
    run_add("7+8 disturbed", 4'd7, 4'd8, 4'd15, 1'b0, 1'b0, 1'b0, 1);

    // No second done from the ignored mid-RUN start.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("no extra done", 32'(pulses), 32'd0);

    // Reset during RUN aborts the operation.
    @(negedge clk);
    A = 4'd6; B = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort R", 32'(R), 32'd0);
    check("abort flags", {29'd0, C, V, Z}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    run_add("2+3", 4'd2, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 0);

    // start held high for 20 cycles: one result every M+2 cycles.
    @(negedge clk);
    A = 4'd1; B = 4'd1; start = 1'b1;
    pulses = 0; busy_low = 0; last_done = -1; gap_bad = 0; r_bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (done) begin
        pulses++;
        if (R !== 4'd2) r_bad++;
        if (last_done >= 0 && (i - last_done) != M + 2) gap_bad++;
        if (last_done < 0 && i != M + 1) gap_bad++;
        last_done = i;
      end
    end
    start = 1'b0;
    check("held pulses", 32'(pulses), 32'd3);
    check("held gap", 32'(gap_bad), 32'd0);
    check("held R", 32'(r_bad), 32'd0);
    check("held busy_low", 32'(busy_low), 32'd6);

    // Drain the operation still in flight, bounded.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy && !done) break;
    end
    check("drain idle", {30'd0, busy, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
